uart_port_ctrl: RTL and testbench
=================================

Name: uart_port_ctrl

Overview:
Sequences the byte-wide UART transmitter and receiver on behalf of the multicycle core's SENDB/RECVB instructions. It is the core-side UART controller. It buffers incoming bytes in an RX FIFO so that bytes arriving outside a RECVB are not lost. It returns a one-cycle completion pulse that the core's wait states poll. It sits between the core control/datapath and the uart_tx/uart_rx serialisers.

Parameters:
FIFO_DEPTH, 16, RX FIFO entries; power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of rx_count

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
core_req  in  1  single-cycle request pulse from core
core_send  in  1  qualifies core_req: 1 = SENDB, 0 = RECVB
core_wdata  in  8  byte to send; sampled with core_req
core_done  out  1  one-cycle completion pulse
core_rdata  out  8  received byte; valid from core_done until next RECVB completes
tx_start  out  1  one-cycle start strobe to transmitter
tx_data  out  8  byte to transmitter; stable from tx_start until tx_busy falls
tx_busy  in  1  transmitter busy; rises the cycle after tx_start, falls after stop bit
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
ovf_clr  in  1  clears rx_overflow
rx_count  out  CNT_W  current FIFO occupancy
rx_overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async, any state): state=IDLE, FIFO empty, rx_count=0, rx_overflow=0, core_done=0, core_rdata=0, tx_start=0, tx_data=0. An in-flight request is abandoned and no core_done is issued.
- FSM states: IDLE, TX_ISSUE, TX_WAIT, RX_WAIT, DONE.
- IDLE:
  - core_req & core_send: latch core_wdata into tx_data, go to TX_ISSUE.
  - core_req & ~core_send: go to RX_WAIT.
- TX_ISSUE:
  - If tx_busy=0: assert tx_start for exactly this cycle, go to TX_WAIT.
  - Otherwise hold in TX_ISSUE.
- TX_WAIT:
  - Ignore tx_busy in the first cycle of the state.
  - Afterwards, go to DONE on the first cycle with tx_busy=0.
- RX_WAIT:
  - If rx_count != 0: pop the FIFO head into core_rdata (registered), go to DONE.
  - Otherwise wait indefinitely.
- DONE: core_done=1 for this cycle only, then go to IDLE.
- Latency:
  - RECVB with a non-empty FIFO: core_done 2 cycles after the core_req cycle.
  - SENDB with an idle transmitter: tx_start 1 cycle after core_req; core_done 1 cycle after tx_busy falls.
- core_req outside IDLE is ignored; it does not queue.
- FIFO push on rx_valid, in any state including non-IDLE.
- Full FIFO (rx_count=FIFO_DEPTH):
  - rx_valid without a pop in the same cycle: byte dropped, rx_overflow set.
  - rx_valid with a pop in the same cycle: both occur, nothing dropped, count unchanged.
- Empty FIFO with rx_valid during RX_WAIT: push this cycle, pop next cycle. There is no bypass.
- rx_overflow set and ovf_clr in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH.
- rx_count is a registered counter: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- tx_data holds its value after completion until the next SENDB latch.

Decomposition:
- Package uart_ctrl_pkg holds:
  - ctrl_state_t enum, logic [2:0]: IDLE, TX_ISSUE, TX_WAIT, RX_WAIT, DONE.
  - DEFAULT_FIFO_DEPTH = 16.
- Sub-module uart_rx_fifo: synchronous FIFO parameterised by depth.
  - Ports: push, pop, din, dout, count, full, empty.
  - Pop is ignored when empty; push is ignored when full unless popping.
  - Reset is asynchronous, active-high.
- The top module holds the FSM, tx_data latch, core_rdata register and overflow flag.

Test Plan:
- RX then RECVB: rx_valid with 0x41 and 0x42 while IDLE, then core_req, core_send=0 → core_done 2 cycles later with core_rdata=0x41; a second RECVB returns 0x42; rx_count ends at 0.
- RECVB on empty FIFO: core_req(recv), wait 10 cycles with no core_done, then rx_valid with 0x5A → core_done 2 cycles after rx_valid, core_rdata=0x5A.
- SENDB with transmitter busy: tx_busy=1, then core_req(send, 0xC3) → no tx_start until tx_busy=0; then a single tx_start with tx_data=0xC3; model tx_busy high 20 cycles → core_done 1 cycle after it falls.
- Overflow: 17 rx_valid bytes 0x00..0x10 with no RECVB (depth 16) → rx_count=16, rx_overflow=1; reads return 0x00..0x0F; ovf_clr clears the flag.
- Full plus simultaneous push/pop: FIFO full, RX_WAIT pop coincides with rx_valid 0x99 → no overflow, rx_count stays 16, 0x99 is the last byte read.
- Async reset mid-TX: assert rst during TX_WAIT → all outputs zero immediately; after release, no core_done appears and the next core_req is accepted from IDLE.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the core-side UART controller.
package uart_ctrl_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        TX_ISSUE,
        TX_WAIT,
        RX_WAIT,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous RX FIFO with an occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_port_ctrl.sv
// Core-side UART controller: sequences SENDB/RECVB against the serialisers.
// state    | meaning
// IDLE     | waiting for core_req
// TX_ISSUE | byte latched, waiting for an idle transmitter to strobe tx_start
// TX_WAIT  | transmitter running, wait for tx_busy to fall
// RX_WAIT  | waiting for the FIFO to hold a byte, then pop it
// DONE     | one-cycle core_done pulse
module uart_port_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_req,
    input  logic             core_send,
    input  logic [7:0]       core_wdata,
    output logic             core_done,
    output logic [7:0]       core_rdata,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_overflow
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        tx_first;
    logic        pop_req;
    logic        drop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (pop_req),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (rx_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign drop = rx_valid & fifo_full & ~pop_req;

    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        core_done  = 1'b0;
        pop_req    = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) next_state = core_send ? TX_ISSUE : RX_WAIT;
            end
            TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // tx_busy may still be low in the first cycle after the strobe.
                if (!tx_first && !tx_busy) next_state = DONE;
            end
            RX_WAIT: begin
                if (!fifo_empty) begin
                    pop_req    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                core_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_first    <= 1'b0;
            tx_data     <= '0;
            core_rdata  <= '0;
            rx_overflow <= 1'b0;
        end else begin
            state    <= next_state;
            tx_first <= tx_start;
            if (state == IDLE && core_req && core_send) tx_data <= core_wdata;
            if (pop_req) core_rdata <= fifo_dout;
            if (drop)         rx_overflow <= 1'b1;
            else if (ovf_clr) rx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Randomised self-checking bench for uart_port_ctrl against a queue-based model.
module tb_uart_port_ctrl;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core_req = 1'b0;
    logic             core_send = 1'b0;
    logic [7:0]       core_wdata = '0;
    logic             core_done;
    logic [7:0]       core_rdata;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] rx_count;
    logic             rx_overflow;

    logic tx_busy_m  = 1'b0;
    logic busy_force = 1'b0;
    assign tx_busy = tx_busy_m | busy_force;

    int         checks = 0;
    int         failures = 0;
    int         tx_len = 3;
    int         n_start = 0;
    logic [7:0] start_data = '0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;

    uart_port_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_send   (core_send),
        .core_wdata  (core_wdata),
        .core_done   (core_done),
        .core_rdata  (core_rdata),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .ovf_clr     (ovf_clr),
        .rx_count    (rx_count),
        .rx_overflow (rx_overflow)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after tx_start and stays high tx_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && rst === 1'b0) begin
                n_start++;
                start_data = tx_data;
                @(posedge clk);
                #1 tx_busy_m = 1'b1;
                repeat (tx_len) @(posedge clk);
                #1 tx_busy_m = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check_state;
        chk("rx_count", 32'(rx_count), q.size());
        chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    endtask

    // Returns the number of ticks until core_done is seen, or -1 on timeout.
    task automatic wait_done(input int bound, input bit poke, input logic [7:0] poke_byte, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            if (poke && i == 2) begin
                core_req   = 1'b1;
                core_send  = 1'($urandom_range(0, 1));
                core_wdata = poke_byte;
            end
            tick;
            core_req = 1'b0;
            if (core_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit clr);
        rx_valid = 1'b1;
        rx_data  = b;
        ovf_clr  = clr;
        tick;
        rx_valid = 1'b0;
        ovf_clr  = 1'b0;
        if (q.size() < DEPTH) begin
            q.push_back(b);
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic clear_ovf;
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    // RECVB: with data present core_done is 2 cycles after the request cycle,
    // which is the first tick after the request tick.
    task automatic recvb(input int idle_wait, input logic [7:0] late_byte);
        int n;
        logic [7:0] exp;
        core_req  = 1'b1;
        core_send = 1'b0;
        tick;
        core_req = 1'b0;
        if (q.size() != 0) begin
            exp = q.pop_front();
            wait_done(8, 1'b0, 8'h00, n);
            chk("recv_latency", n, 1);
            chk("recv_data", 32'(core_rdata), 32'(exp));
        end else begin
            for (int i = 0; i < idle_wait; i++) begin
                tick;
                chk("recv_empty_nodone", 32'(core_done), 0);
            end
            rx_valid = 1'b1;
            rx_data  = late_byte;
            tick;
            rx_valid = 1'b0;
            wait_done(8, 1'b0, 8'h00, n);
            chk("recv_late_latency", n, 1);
            chk("recv_late_data", 32'(core_rdata), 32'(late_byte));
        end
        tick;
        chk("recv_done_pulse", 32'(core_done), 0);
    endtask

    // SENDB: core_done one cycle after tx_busy falls, i.e. len+2 ticks after the
    // request (or after the forced-busy release).
    task automatic sendb(input logic [7:0] b, input int len, input int hold, input bit poke);
        int n;
        int n0;
        n0         = n_start;
        tx_len     = len;
        busy_force = (hold > 0);
        core_req   = 1'b1;
        core_send  = 1'b1;
        core_wdata = b;
        tick;
        core_req   = 1'b0;
        core_wdata = 8'($urandom);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("send_held_no_start", n_start, n0);
        end
        busy_force = 1'b0;
        wait_done(len + 20, poke, ~b, n);
        chk("send_latency", n, len + 2);
        chk("tx_start_count", n_start, n0 + 1);
        chk("tx_start_data", 32'(start_data), 32'(b));
        chk("tx_data_hold", 32'(tx_data), 32'(b));
        tick;
        chk("send_done_pulse", 32'(core_done), 0);
    endtask

    initial begin
        int cnt;
        int op;
        logic [7:0] exp;

        repeat (3) tick;
        chk("rst_core_done", 32'(core_done), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_core_rdata", 32'(core_rdata), 0);
        check_state;
        rst = 1'b0;
        tick;

        rx_byte(8'h41, 1'b0);
        rx_byte(8'h42, 1'b0);
        check_state;
        recvb(0, 8'h00);
        recvb(0, 8'h00);
        check_state;

        recvb(10, 8'h5A);
        check_state;

        sendb(8'hC3, 20, 5, 1'b0);

        for (int i = 0; i <= 16; i++) rx_byte(8'(i), 1'b0);
        check_state;
        rx_byte(8'hEE, 1'b1);
        check_state;
        clear_ovf;
        check_state;

        // Full FIFO: a pop and a push in the same cycle, nothing dropped.
        core_req  = 1'b1;
        core_send = 1'b0;
        tick;
        core_req = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick;
        rx_valid = 1'b0;
        exp = q.pop_front();
        q.push_back(8'h99);
        chk("full_pushpop_done", 32'(core_done), 1);
        chk("full_pushpop_data", 32'(core_rdata), 32'(exp));
        check_state;
        tick;
        while (q.size() != 0) recvb(0, 8'h00);
        chk("full_pushpop_last", 32'(core_rdata), 32'h99);
        check_state;

        sendb(8'h5A, 4, 0, 1'b1);
        cnt = 0;
        repeat (4) begin
            tick;
            if (core_done) cnt++;
        end
        chk("poke_no_queued_done", cnt, 0);

        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3)      rx_byte(8'($urandom), ($urandom_range(0, 7) == 0));
            else if (op <= 6) recvb(int'($urandom_range(0, 4)), 8'($urandom));
            else if (op <= 8) sendb(8'($urandom), int'($urandom_range(1, 8)),
                                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                                    1'($urandom_range(0, 1)));
            else              clear_ovf;
            check_state;
        end

        // Asynchronous reset in the middle of a transmission.
        rx_byte(8'h77, 1'b0);
        tx_len     = 30;
        core_req   = 1'b1;
        core_send  = 1'b1;
        core_wdata = 8'hA5;
        tick;
        core_req = 1'b0;
        repeat (4) tick;
        #1 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk("arst_core_done", 32'(core_done), 0);
        chk("arst_tx_start", 32'(tx_start), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_core_rdata", 32'(core_rdata), 0);
        check_state;
        tick;
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            tick;
            if (core_done) cnt++;
        end
        chk("arst_no_done", cnt, 0);
        sendb(8'h3C, 2, 0, 1'b0);
        rx_byte(8'h12, 1'b0);
        recvb(0, 8'h00);
        check_state;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
